// File: rtl/cr_huf_comp_sc_packer_if.sv
// Eob code type plus the symbol-in / packed-run-word-out bundle of the
// Huffman run-length packer.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_comp_pkg;
  typedef enum logic [1:0] {
    PIPE_EOB_NONE  = 2'd0,
    PIPE_EOB_FINAL = 2'd1,
    PIPE_EOB_FLUSH = 2'd2,
    PIPE_EOB_ABORT = 2'd3
  } e_pipe_eob;
endpackage

interface cr_huf_comp_sc_packer_if #(
  parameter int DAT_WIDTH   = 10,
  parameter int CNT_WIDTH   = 3,
  parameter int CNTRL_WIDTH = 1
);
  import cr_huf_comp_pkg::*;

  logic                              in_vld;
  logic [DAT_WIDTH-1:0]              in_sym;
  logic [CNTRL_WIDTH-1:0]            in_meta;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] in_seq_id;
  e_pipe_eob                         in_eob;
  logic                              sc_in_rdy;

  logic [3:0]                        sc_is_vld;
  logic [DAT_WIDTH-1:0]              sc_is_sym0;
  logic [DAT_WIDTH-1:0]              sc_is_sym1;
  logic [DAT_WIDTH-1:0]              sc_is_sym2;
  logic [DAT_WIDTH-1:0]              sc_is_sym3;
  logic [CNT_WIDTH-1:0]              sc_is_cnt0;
  logic [CNT_WIDTH-1:0]              sc_is_cnt1;
  logic [CNT_WIDTH-1:0]              sc_is_cnt2;
  logic [CNT_WIDTH-1:0]              sc_is_cnt3;
  logic [CNTRL_WIDTH-1:0]            sc_is_meta;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] sc_is_seq_id;
  e_pipe_eob                         sc_is_eob;
  logic                              is_sc_rd;

  modport slave (
    input  in_vld, in_sym, in_meta, in_seq_id, in_eob, is_sc_rd,
    output sc_in_rdy, sc_is_vld, sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3,
           sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3,
           sc_is_meta, sc_is_seq_id, sc_is_eob
  );

  modport master (
    output in_vld, in_sym, in_meta, in_seq_id, in_eob, is_sc_rd,
    input  sc_in_rdy, sc_is_vld, sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3,
           sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3,
           sc_is_meta, sc_is_seq_id, sc_is_eob
  );
endinterface

// File: rtl/cr_huf_comp_sc_packer.sv
// Run-length packer: folds a symbol stream into (sym, cnt) runs and emits
// them four at a time in a registered output word.
//
// state    | meaning
// ST_FILL  | accepting symbols, building runs into the pack
// ST_WAIT  | pack full mid-block, waiting for the output register
// ST_SPILL | full pack plus a held eob run still to be emitted
// ST_LAST  | pack holds the block's final run, emits with eob
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module cr_huf_comp_sc_packer
  import cr_huf_comp_pkg::*;
#(
  parameter int DAT_WIDTH   = 10,
  parameter int CNT_WIDTH   = 3,
  parameter int CNTRL_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cr_huf_comp_sc_packer_if.slave sc_if
);

  localparam int SEQW = `CREOLE_HC_SEQID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_SPILL, ST_LAST} state_e;

  state_e                           state_q, state_d;
  logic                             run_vld_q, run_vld_d;
  logic [DAT_WIDTH-1:0]             run_sym_q, run_sym_d;
  logic [CNT_WIDTH-1:0]             run_cnt_q, run_cnt_d;
  logic [2:0]                       fill_q, fill_d;
  logic [3:0][DAT_WIDTH-1:0]        pack_sym_q, pack_sym_d;
  logic [3:0][CNT_WIDTH-1:0]        pack_cnt_q, pack_cnt_d;
  logic [CNTRL_WIDTH-1:0]           pack_meta_q, pack_meta_d;
  logic [SEQW-1:0]                  pack_seq_q, pack_seq_d;
  e_pipe_eob                        pack_eob_q, pack_eob_d;
  logic [3:0]                       out_vld_q, out_vld_d;
  logic [3:0][DAT_WIDTH-1:0]        out_sym_q, out_sym_d;
  logic [3:0][CNT_WIDTH-1:0]        out_cnt_q, out_cnt_d;
  logic [CNTRL_WIDTH-1:0]           out_meta_q, out_meta_d;
  logic [SEQW-1:0]                  out_seq_q, out_seq_d;
  e_pipe_eob                        out_eob_q, out_eob_d;

  logic       accept, is_final, merge, out_free, pack_load;
  logic [1:0] slot, slot_nx;

  always_comb begin
    state_d     = state_q;
    run_vld_d   = run_vld_q;
    run_sym_d   = run_sym_q;
    run_cnt_d   = run_cnt_q;
    fill_d      = fill_q;
    pack_sym_d  = pack_sym_q;
    pack_cnt_d  = pack_cnt_q;
    pack_meta_d = pack_meta_q;
    pack_seq_d  = pack_seq_q;
    pack_eob_d  = pack_eob_q;
    pack_load   = 1'b0;
    slot        = fill_q[1:0];
    slot_nx     = fill_q[1:0] + 2'd1;
    accept      = sc_if.in_vld && (state_q == ST_FILL);
    is_final    = (sc_if.in_eob != PIPE_EOB_NONE);
    merge       = run_vld_q && (sc_if.in_sym == run_sym_q) && (run_cnt_q != CNT_MAX);
    out_free    = (out_vld_q == 4'd0) || sc_if.is_sc_rd;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (fill_q == 3'd0) begin
            pack_meta_d = sc_if.in_meta;
            pack_seq_d  = sc_if.in_seq_id;
          end
          if (!is_final) begin
            if (merge) begin
              run_cnt_d = run_cnt_q + CNT_ONE;
            end else begin
              if (run_vld_q) begin
                pack_sym_d[slot] = run_sym_q;
                pack_cnt_d[slot] = run_cnt_q;
                fill_d           = fill_q + 3'd1;
                if (fill_q == 3'd3) state_d = ST_WAIT;
              end
              run_vld_d = 1'b1;
              run_sym_d = sc_if.in_sym;
              run_cnt_d = CNT_ONE;
            end
          end else begin
            pack_eob_d = sc_if.in_eob;
            run_vld_d  = 1'b0;
            run_sym_d  = '0;
            run_cnt_d  = '0;
            state_d    = ST_LAST;
            if (merge) begin
              pack_sym_d[slot] = run_sym_q;
              pack_cnt_d[slot] = run_cnt_q + CNT_ONE;
              fill_d           = fill_q + 3'd1;
            end else if (!run_vld_q) begin
              pack_sym_d[slot] = sc_if.in_sym;
              pack_cnt_d[slot] = CNT_ONE;
              fill_d           = fill_q + 3'd1;
            end else begin
              pack_sym_d[slot] = run_sym_q;
              pack_cnt_d[slot] = run_cnt_q;
              if (fill_q == 3'd3) begin
                // no room for the eob run: park it in the run register
                fill_d    = 3'd4;
                run_vld_d = 1'b1;
                run_sym_d = sc_if.in_sym;
                run_cnt_d = CNT_ONE;
                state_d   = ST_SPILL;
              end else begin
                pack_sym_d[slot_nx] = sc_if.in_sym;
                pack_cnt_d[slot_nx] = CNT_ONE;
                fill_d              = fill_q + 3'd2;
              end
            end
          end
        end
      end
      ST_WAIT: begin
        if (out_free) begin
          pack_load  = 1'b1;
          fill_d     = 3'd0;
          pack_sym_d = '0;
          pack_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      ST_SPILL: begin
        if (out_free) begin
          pack_load     = 1'b1;
          pack_sym_d    = '0;
          pack_cnt_d    = '0;
          pack_sym_d[0] = run_sym_q;
          pack_cnt_d[0] = run_cnt_q;
          fill_d        = 3'd1;
          run_vld_d     = 1'b0;
          run_sym_d     = '0;
          run_cnt_d     = '0;
          state_d       = ST_LAST;
        end
      end
      ST_LAST: begin
        if (out_free) begin
          pack_load   = 1'b1;
          fill_d      = 3'd0;
          pack_sym_d  = '0;
          pack_cnt_d  = '0;
          pack_meta_d = '0;
          pack_seq_d  = '0;
          pack_eob_d  = PIPE_EOB_NONE;
          run_vld_d   = 1'b0;
          run_sym_d   = '0;
          run_cnt_d   = '0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    out_vld_d  = out_vld_q;
    out_sym_d  = out_sym_q;
    out_cnt_d  = out_cnt_q;
    out_meta_d = out_meta_q;
    out_seq_d  = out_seq_q;
    out_eob_d  = out_eob_q;
    if (pack_load) begin
      out_vld_d  = '0;
      out_sym_d  = '0;
      out_cnt_d  = '0;
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < fill_q) begin
          out_vld_d[i] = 1'b1;
          out_sym_d[i] = pack_sym_q[i];
          out_cnt_d[i] = pack_cnt_q[i];
        end
      end
      out_meta_d = pack_meta_q;
      out_seq_d  = pack_seq_q;
      out_eob_d  = (state_q == ST_LAST) ? pack_eob_q : PIPE_EOB_NONE;
    end else if (sc_if.is_sc_rd && (out_vld_q != 4'd0)) begin
      out_vld_d  = '0;
      out_sym_d  = '0;
      out_cnt_d  = '0;
      out_meta_d = '0;
      out_seq_d  = '0;
      out_eob_d  = PIPE_EOB_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      run_vld_q   <= 1'b0;
      run_sym_q   <= '0;
      run_cnt_q   <= '0;
      fill_q      <= '0;
      pack_sym_q  <= '0;
      pack_cnt_q  <= '0;
      pack_meta_q <= '0;
      pack_seq_q  <= '0;
      pack_eob_q  <= PIPE_EOB_NONE;
      out_vld_q   <= '0;
      out_sym_q   <= '0;
      out_cnt_q   <= '0;
      out_meta_q  <= '0;
      out_seq_q   <= '0;
      out_eob_q   <= PIPE_EOB_NONE;
    end else begin
      state_q     <= state_d;
      run_vld_q   <= run_vld_d;
      run_sym_q   <= run_sym_d;
      run_cnt_q   <= run_cnt_d;
      fill_q      <= fill_d;
      pack_sym_q  <= pack_sym_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_meta_q <= pack_meta_d;
      pack_seq_q  <= pack_seq_d;
      pack_eob_q  <= pack_eob_d;
      out_vld_q   <= out_vld_d;
      out_sym_q   <= out_sym_d;
      out_cnt_q   <= out_cnt_d;
      out_meta_q  <= out_meta_d;
      out_seq_q   <= out_seq_d;
      out_eob_q   <= out_eob_d;
    end
  end

  assign sc_if.sc_in_rdy    = (state_q == ST_FILL);
  assign sc_if.sc_is_vld    = out_vld_q;
  assign sc_if.sc_is_sym0   = out_sym_q[0];
  assign sc_if.sc_is_sym1   = out_sym_q[1];
  assign sc_if.sc_is_sym2   = out_sym_q[2];
  assign sc_if.sc_is_sym3   = out_sym_q[3];
  assign sc_if.sc_is_cnt0   = out_cnt_q[0];
  assign sc_if.sc_is_cnt1   = out_cnt_q[1];
  assign sc_if.sc_is_cnt2   = out_cnt_q[2];
  assign sc_if.sc_is_cnt3   = out_cnt_q[3];
  assign sc_if.sc_is_meta   = out_meta_q;
  assign sc_if.sc_is_seq_id = out_seq_q;
  assign sc_if.sc_is_eob    = out_eob_q;

endmodule

// File: tb/tb_cr_huf_comp_sc_packer.sv
// Bench for the run-length packer: directed block cases, back-pressure and
// reset, then random blocks checked against a segment-and-chunk run model.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module tb_cr_huf_comp_sc_packer;
  import cr_huf_comp_pkg::*;

  localparam int DW   = 10;
  localparam int CW   = 3;
  localparam int MW   = 1;
  localparam int SW   = `CREOLE_HC_SEQID_WIDTH;
  localparam int RMAX = (1 << CW) - 1;
  localparam int NSYM = 6;

  typedef struct packed {
    logic [3:0]         vld;
    logic [3:0][DW-1:0] sym;
    logic [3:0][CW-1:0] cnt;
    logic [MW-1:0]      meta;
    logic [SW-1:0]      seq;
    logic [1:0]         eob;
  } word_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    noncontig = 0;
  int    rd_mode = 0;
  int    hist_in[NSYM];
  int    hist_out[NSYM];
  word_t got_q[$];
  word_t exp_q[$];

  cr_huf_comp_sc_packer_if #(.DAT_WIDTH(DW), .CNT_WIDTH(CW), .CNTRL_WIDTH(MW)) sc_if ();

  cr_huf_comp_sc_packer #(.DAT_WIDTH(DW), .CNT_WIDTH(CW), .CNTRL_WIDTH(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sc_if (sc_if)
  );

  always #5 clk = ~clk;

  // reader: 0 = hold off, 1 = always pop, 2 = random pops
  always @(posedge clk) begin
    #2;
    if (rd_mode == 0)      sc_if.is_sc_rd = 1'b0;
    else if (rd_mode == 1) sc_if.is_sc_rd = 1'b1;
    else                   sc_if.is_sc_rd = 1'($urandom_range(0, 1));
  end

  // collects every word that is popped, and watches the slot mask shape
  always @(negedge clk) begin
    word_t w;
    w        = '0;
    w.vld    = sc_if.sc_is_vld;
    w.sym[0] = sc_if.sc_is_sym0;
    w.sym[1] = sc_if.sc_is_sym1;
    w.sym[2] = sc_if.sc_is_sym2;
    w.sym[3] = sc_if.sc_is_sym3;
    w.cnt[0] = sc_if.sc_is_cnt0;
    w.cnt[1] = sc_if.sc_is_cnt1;
    w.cnt[2] = sc_if.sc_is_cnt2;
    w.cnt[3] = sc_if.sc_is_cnt3;
    w.meta   = sc_if.sc_is_meta;
    w.seq    = sc_if.sc_is_seq_id;
    w.eob    = sc_if.sc_is_eob;
    if (rst_n && !(w.vld inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF})) noncontig++;
    if (rst_n && (w.vld != 4'h0) && sc_if.is_sc_rd) got_q.push_back(w);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t mk(input logic [3:0] v, input int s0, c0, s1, c1, s2, c2,
                               s3, c3, input int m, sq, eb);
    word_t w;
    w        = '0;
    w.vld    = v;
    w.sym[0] = DW'(s0); w.cnt[0] = CW'(c0);
    w.sym[1] = DW'(s1); w.cnt[1] = CW'(c1);
    w.sym[2] = DW'(s2); w.cnt[2] = CW'(c2);
    w.sym[3] = DW'(s3); w.cnt[3] = CW'(c3);
    w.meta   = MW'(m);
    w.seq    = SW'(sq);
    w.eob    = 2'(eb);
    return w;
  endfunction

  function automatic word_t word_at(input int k);
    if (k < got_q.size()) return got_q[k];
    return '0;
  endfunction

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int s, input int e);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    sc_if.in_vld = 1'b1;
    sc_if.in_sym = DW'(s);
    sc_if.in_eob = e_pipe_eob'(2'(e));
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = sc_if.sc_in_rdy;
      n++;
      @(posedge clk);
      #1;
    end
    sc_if.in_vld = 1'b0;
    sc_if.in_eob = PIPE_EOB_NONE;
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_words(input int n, input string tag);
    int c;
    c = 0;
    while (got_q.size() < n && c < 600) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_word_count"}, got_q.size(), n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, sc_if.sc_is_vld, 0);
    chk({tag, "_rdy"}, sc_if.sc_in_rdy, 1);
    chk({tag, "_syms"}, {sc_if.sc_is_sym0, sc_if.sc_is_sym1, sc_if.sc_is_sym2, sc_if.sc_is_sym3}, 0);
    chk({tag, "_cnts"}, {sc_if.sc_is_cnt0, sc_if.sc_is_cnt1, sc_if.sc_is_cnt2, sc_if.sc_is_cnt3}, 0);
    chk({tag, "_meta_seq_eob"}, {sc_if.sc_is_meta, sc_if.sc_is_seq_id, sc_if.sc_is_eob}, 0);
  endtask

  initial begin
    sc_if.in_vld    = 1'b0;
    sc_if.in_sym    = '0;
    sc_if.in_meta   = '0;
    sc_if.in_seq_id = '0;
    sc_if.in_eob    = PIPE_EOB_NONE;
    for (int s = 0; s < NSYM; s++) begin
      hist_in[s]  = 0;
      hist_out[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // merge then eob merge: 5,5,5,9,9(eob)
    rd_mode = 1;
    sc_if.in_meta = 1'b1; sc_if.in_seq_id = SW'(5);
    send(5, 0); send(5, 0); send(5, 0); send(9, 0); send(9, 1);
    wait_words(1, "merge");
    chk("merge_word", word_at(0), mk(4'h3, 5, 3, 9, 2, 0, 0, 0, 0, 1, 5, 1));

    // saturation: ten 3s split 7 + 3
    got_q.delete();
    sc_if.in_meta = 1'b0; sc_if.in_seq_id = SW'(2);
    for (int i = 0; i < 10; i++) send(3, (i == 9) ? 2 : 0);
    wait_words(1, "sat");
    chk("sat_word", word_at(0), mk(4'h3, 3, 7, 3, 3, 0, 0, 0, 0, 0, 2, 2));

    // spill: 1,2,3,4,5(eob) needs a fifth slot
    got_q.delete();
    sc_if.in_meta = 1'b1; sc_if.in_seq_id = SW'(7);
    for (int s = 1; s <= 5; s++) send(s, (s == 5) ? 3 : 0);
    wait_words(2, "spill");
    chk("spill_word_a", word_at(0), mk(4'hF, 1, 1, 2, 1, 3, 1, 4, 1, 1, 7, 0));
    chk("spill_word_b", word_at(1), mk(4'h1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 7, 3));

    // back-pressure: reader idle, second full pack stalls in WAIT
    got_q.delete();
    rd_mode = 0;
    sc_if.in_meta = 1'b0; sc_if.in_seq_id = SW'(9);
    for (int s = 11; s <= 19; s++) send(s, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_rdy_low", sc_if.sc_in_rdy, 0);
      chk("bp_hold_vld", sc_if.sc_is_vld, 4'hF);
      chk("bp_hold_syms", {sc_if.sc_is_sym0, sc_if.sc_is_sym3}, {DW'(11), DW'(14)});
    end
    @(posedge clk); #1;
    rd_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_reload_vld", sc_if.sc_is_vld, 4'hF);
    chk("bp_reload_syms", {sc_if.sc_is_sym0, sc_if.sc_is_sym3}, {DW'(15), DW'(18)});
    chk("bp_first_word", word_at(0), mk(4'hF, 11, 1, 12, 1, 13, 1, 14, 1, 0, 9, 0));
    @(posedge clk); #1;
    rd_mode = 0;

    // reset while stalled in WAIT with a word pending
    for (int s = 20; s <= 27; s++) send(s, 0);
    @(negedge clk);
    chk("wait_rdy_low", sc_if.sc_in_rdy, 0);
    chk("wait_pending_vld", sc_if.sc_is_vld, 4'hF);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    got_q.delete();
    rd_mode = 1;
    sc_if.in_meta = 1'b1; sc_if.in_seq_id = SW'(33);
    @(posedge clk); #1;
    send(7, 0); send(7, 0); send(8, 1);
    wait_words(1, "post_rst");
    chk("post_rst_word", word_at(0), mk(4'h3, 7, 2, 8, 1, 0, 0, 0, 0, 1, 33, 1));

    // random blocks, random reader
    got_q.delete();
    exp_q.delete();
    rd_mode = 2;
    for (int b = 0; b < 30; b++) begin
      int    len, cur, eb, i, j, seg, c, n;
      int    syms[$];
      int    rs[$];
      int    rc[$];
      word_t w;
      len = $urandom_range(1, 24);
      cur = $urandom_range(0, NSYM - 1);
      eb  = $urandom_range(1, 3);
      syms.delete(); rs.delete(); rc.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) < 3) cur = $urandom_range(0, NSYM - 1);
        syms.push_back(cur);
        hist_in[cur] += 1;
      end
      // maximal equal segments, each cut into chunks of at most RMAX
      i = 0;
      while (i < len) begin
        j = i;
        while (j < len && syms[j] == syms[i]) j++;
        seg = j - i;
        while (seg > 0) begin
          c = (seg > RMAX) ? RMAX : seg;
          rs.push_back(syms[i]);
          rc.push_back(c);
          seg -= c;
        end
        i = j;
      end
      sc_if.in_meta   = MW'($urandom_range(0, 1));
      sc_if.in_seq_id = SW'($urandom_range(0, 255));
      for (int k = 0; k < rs.size(); k += 4) begin
        n = ((rs.size() - k) > 4) ? 4 : (rs.size() - k);
        w = '0;
        for (int m = 0; m < n; m++) begin
          w.vld[m] = 1'b1;
          w.sym[m] = DW'(rs[k + m]);
          w.cnt[m] = CW'(rc[k + m]);
        end
        w.meta = sc_if.in_meta;
        w.seq  = sc_if.in_seq_id;
        w.eob  = (k + 4 >= rs.size()) ? 2'(eb) : 2'd0;
        exp_q.push_back(w);
      end
      for (int k = 0; k < len; k++) send(syms[k], (k == len - 1) ? eb : 0);
    end
    rd_mode = 1;
    wait_words(exp_q.size(), "rand");
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("rand_word%0d", k), word_at(k), exp_q[k]);
    for (int k = 0; k < got_q.size(); k++)
      for (int m = 0; m < 4; m++)
        if (got_q[k].vld[m] && got_q[k].sym[m] < DW'(NSYM))
          hist_out[int'(got_q[k].sym[m])] += int'(got_q[k].cnt[m]);
    for (int s = 0; s < NSYM; s++)
      chk($sformatf("hist_sym%0d", s), hist_out[s], hist_in[s]);
    chk("vld_contiguous", noncontig, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cr_huf_comp_sc_packer.md
CR_HUF_COMP_SC_PACKER -- requirements
Module: cr_huf_comp_sc_packer

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 10, meaning symbol width.
REQ-002 SHALL have parameter CNT_WIDTH, default 3, meaning run-count field width; the maximum run length is 2^CNT_WIDTH-1.
REQ-003 SHALL have parameter CNTRL_WIDTH, default 1, meaning meta width.
REQ-004 One clock and an asynchronous active-low reset: clk  input  1  clock; rst_n  input  1  async active-low reset.
REQ-005 in_vld  input  1  upstream symbol valid.
REQ-006 in_sym  input  DAT_WIDTH  symbol.
REQ-007 in_meta  input  CNTRL_WIDTH  meta; constant from the first symbol of a block through its eob symbol.
REQ-008 in_seq_id  input  `CREOLE_HC_SEQID_WIDTH  sequence id; held constant the same way as in_meta.
REQ-009 in_eob  input  e_pipe_eob  eob code; encoding 0 means not-final.
REQ-010 sc_in_rdy  output  1  symbol accepted on a clk edge where in_vld & sc_in_rdy.
REQ-011 sc_is_vld  output  4  slot-valid mask; contiguous from bit 0.
REQ-012 sc_is_sym0..3  output  DAT_WIDTH each  run symbols.
REQ-013 sc_is_cnt0..3  output  CNT_WIDTH each  run lengths.
REQ-014 sc_is_meta  output  CNTRL_WIDTH  meta.
REQ-015 sc_is_seq_id  output  `CREOLE_HC_SEQID_WIDTH  sequence id.
REQ-016 sc_is_eob  output  e_pipe_eob  eob code.
REQ-017 is_sc_rd  input  1  pops the output word when sc_is_vld!=0; ignored when sc_is_vld==0.

Function
REQ-018 Open run register (sym, cnt, valid):
- accepted in_sym == open sym and cnt < max: cnt+1.
- otherwise: open run closes into the next free pack slot; new run opens with cnt=1.
REQ-019 Pack: 4 slots filled in order 0..3; the meta and seq_id of the pack's first symbol are captured with it.
REQ-020 Output register: loaded from the pack (slot mask, syms, cnts, meta, seq_id, eob).
- unused slots drive sym=0, cnt=0.
- loads on any edge where the pack is ready and (sc_is_vld==0 or is_sc_rd==1), with no bubble.
REQ-021 FSM states FILL, WAIT, SPILL, LAST; sc_in_rdy=1 only in FILL.
REQ-022 FILL, non-final symbol accepted: run closes per REQ-018; 4th slot filled -> WAIT.
REQ-023 FILL, final symbol (in_eob!=0) accepted, two cases:
- merges or fits: open run is closed into the pack with eob -> LAST.
- pack already holds 3 closed runs and the symbol differs: slot 3 takes the old run; the eob run is held -> SPILL.
REQ-024 WAIT: pack transfers with eob=0 -> FILL with the pack emptied; the open run is retained.
REQ-025 SPILL: 4-slot pack transfers with eob=0; the held eob run loads into slot 0 with in_eob -> LAST.
REQ-026 LAST: pack transfers with eob -> FILL; pack and open run are cleared.
REQ-027 The eob code is driven only on the word containing the final run; all other words drive 0.
REQ-028 A symbol accepted at edge N that closes a run makes that run visible in the pack at edge N; the earliest output load is edge N+1.
REQ-029 Run counts saturate at 2^CNT_WIDTH-1; the next identical symbol starts a new run, never wraps.
REQ-030 Simultaneous is_sc_rd and pack load in the same cycle: the new word replaces the old one and sc_is_vld stays non-zero.
REQ-031 in_vld while sc_in_rdy=0: the symbol is not consumed; upstream holds it.

Reset
REQ-032 On rst_n low, all of the following hold asynchronously:
- FSM=FILL; sc_in_rdy=1.
- pack, open run and output register are cleared.
- sc_is_vld=0, all sym/cnt=0, meta=0, seq_id=0, eob=0.
REQ-033 Reset mid-block discards partial runs and packs; nothing is emitted for them after release.

Verification
REQ-034 Bench SHALL cover: symbols 5,5,5,9 then 9 with eob, is_sc_rd tied 1 -> one word: vld=0011, sym0=5/cnt0=3, sym1=9/cnt1=2, eob!=0.
REQ-035 Bench SHALL cover: 10 x symbol 3, last with eob -> vld=0011, cnt0=7, cnt1=3.
REQ-036 Bench SHALL cover: symbols 1,2,3,4,5, 5 carrying eob -> word A vld=1111 (1,2,3,4; cnt 1 each; eob=0), then word B vld=0001 (sym 5, cnt 1, eob!=0); the SPILL path is taken.
REQ-037 Bench SHALL cover: is_sc_rd held 0 with a word pending and a full pack (WAIT) -> sc_in_rdy=0 and the output is stable; on is_sc_rd=1 the next word loads on the same edge.
REQ-038 Bench SHALL cover: rst_n asserted in WAIT -> all outputs 0 and sc_in_rdy=1 immediately; a fresh block after release packs normally.
REQ-039 Bench SHALL cover: random symbol stream with random is_sc_rd -> the scoreboard sum of cnt per symbol equals the input histogram, and sc_is_vld is always contiguous.
